// File: rtl/timer_pkg.sv
// timer_pkg: shared state and mode encodings for the multimode timer
package timer_pkg;
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN = 1'b1;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/timer_multimode_if.sv
// timer_multimode_if: control and status bundle of the multimode timer
interface timer_multimode_if #(parameter int WIDTH = 16, parameter int PS_WIDTH = 8);
  logic en, start, stop, periodic, clear;
  logic [WIDTH-1:0] load_val, count;
  logic [PS_WIDTH-1:0] prescale;
  logic busy, done, expired;
  modport master(output en, start, stop, periodic, load_val, prescale, clear, input count, busy, done, expired);
  modport slave(input en, start, stop, periodic, load_val, prescale, clear, output count, busy, done, expired);
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: counts enabled cycles and ticks when the count reaches the divisor
module timer_prescaler #(parameter int PS_WIDTH = 8) (
  input logic clk,
  input logic reset,
  input logic clear,
  input logic enable,
  input logic [PS_WIDTH-1:0] divisor,
  output logic tick
);
  logic [PS_WIDTH-1:0] cnt;
  assign tick = enable && cnt == divisor;
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + PS_WIDTH'(1);
endmodule

// File: rtl/timer_multimode.sv
// timer_multimode: one-shot/periodic timer with prescaler, done pulse and sticky expired flag
module timer_multimode
  import timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PS_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  timer_multimode_if.slave bus
);
  state_t state;
  logic [WIDTH-1:0] count, load_r;
  logic [PS_WIDTH-1:0] ps_r;
  logic mode_r, done, expired, tick, run, expiry, fire;
  assign run = state == RUN;
  assign expiry = tick && count == load_r;
  // start and stop both override an expiry landing on the same cycle
  assign fire = expiry && !bus.stop && !bus.start;
  timer_prescaler #(.PS_WIDTH(PS_WIDTH)) u_ps (
    .clk(clk),
    .reset(reset),
    .clear(bus.start | bus.stop),
    .enable(run && bus.en),
    .divisor(ps_r),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      load_r <= '0;
      ps_r <= '0;
      mode_r <= MODE_ONESHOT;
      done <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= fire;
      expired <= fire | (expired & ~bus.clear);
      if (bus.stop) begin
        state <= IDLE;
        count <= '0;
      end else if (bus.start) begin
        state <= RUN;
        count <= '0;
        load_r <= bus.load_val;
        ps_r <= bus.prescale;
        mode_r <= bus.periodic;
      end else if (tick) begin
        count <= expiry ? '0 : count + WIDTH'(1);
        if (expiry && mode_r == MODE_ONESHOT) state <= IDLE;
      end
    end
  end
  assign bus.count = count;
  assign bus.busy = run;
  assign bus.done = done;
  assign bus.expired = expired;
endmodule

// File: tb/tb_timer_multimode.sv
// tb_timer_multimode: directed and random checks against an elapsed-cycle reference model
module tb_timer_multimode;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  int m_l = 0, m_p = 0, n = 0, lat = 0;
  longint m_n = 0;
  bit m_run = 0, m_mode = 0, m_done = 0, m_exp = 0;
  logic [15:0] held;
  timer_multimode_if #(.WIDTH(16), .PS_WIDTH(8)) bus ();
  timer_multimode #(.WIDTH(16), .PS_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // The model tracks enabled RUN cycles since the last (re)load; expiry is the
  // last cycle of each (L+1)*(P+1) window and count is elapsed/(P+1).
  task automatic step();
    bit ev, fire;
    @(posedge clk);
    if (reset) begin
      m_run = 0; m_n = 0; m_l = 0; m_p = 0; m_mode = 0; m_done = 0; m_exp = 0;
    end else begin
      ev = m_run && bus.en && (m_n + 1 == longint'(m_l + 1) * longint'(m_p + 1));
      fire = ev && !bus.stop && !bus.start;
      m_done = fire;
      m_exp = fire | (m_exp & !bus.clear);
      if (bus.stop) begin
        m_run = 0; m_n = 0;
      end else if (bus.start) begin
        m_run = 1; m_n = 0; m_l = int'(bus.load_val); m_p = int'(bus.prescale); m_mode = bus.periodic;
      end else if (m_run && bus.en) begin
        m_n = ev ? 0 : m_n + 1;
        if (ev && !m_mode) m_run = 0;
      end
    end
    #1;
    chk("count", 32'(bus.count), m_run ? 32'(m_n / (m_p + 1)) : 32'd0);
    chk("busy", 32'(bus.busy), 32'(m_run));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("expired", 32'(bus.expired), 32'(m_exp));
  endtask
  task automatic go(int l, int p, bit per);
    bus.load_val = 16'(l); bus.prescale = 8'(p); bus.periodic = per; bus.start = 1;
    step();
    bus.start = 0;
  endtask
  task automatic wait_done(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (bus.done) begin
        cnt = i;
        break;
      end
    end
    chk("wait_bound", 32'(cnt > 0), 32'd1);
  endtask
  initial begin
    bus.en = 0; bus.start = 0; bus.stop = 0; bus.periodic = 0; bus.clear = 0;
    bus.load_val = '0; bus.prescale = '0;
    step(); step();
    reset = 0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    bus.en = 1;
    go(3, 1, 0);
    wait_done(lat);
    chk("oneshot_lat", 32'(lat), 8);
    chk("oneshot_busy", 32'(bus.busy), 0);
    chk("oneshot_count", 32'(bus.count), 0);
    step();
    chk("oneshot_single", 32'(bus.done), 0);
    go(2, 0, 1);
    wait_done(lat);
    chk("per_first", 32'(lat), 3);
    wait_done(lat);
    chk("per_second", 32'(lat), 3);
    step(); step();
    bus.clear = 1;
    step();
    bus.clear = 0;
    chk("per_third_done", 32'(bus.done), 1);
    chk("set_beats_clear", 32'(bus.expired), 1);
    bus.clear = 1;
    step();
    bus.clear = 0;
    chk("clear_works", 32'(bus.expired), 0);
    bus.stop = 1;
    step();
    bus.stop = 0;
    go(3, 1, 0);
    step(); step(); step();
    bus.en = 0;
    held = bus.count;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gap_frozen", 32'(bus.count), 32'(held));
    end
    bus.en = 1;
    wait_done(lat);
    chk("gap_delay", 32'(3 + 5 + lat), 13);
    go(3, 0, 0);
    step(); step();
    chk("ss_count2", 32'(bus.count), 2);
    bus.start = 1; bus.stop = 1;
    step();
    bus.start = 0; bus.stop = 0;
    chk("ss_idle", 32'(bus.busy), 0);
    chk("ss_count0", 32'(bus.count), 0);
    for (int i = 0; i < 6; i++) step();
    go(3, 0, 0);
    step(); step();
    chk("re_count2", 32'(bus.count), 2);
    go(3, 0, 0);
    chk("re_count0", 32'(bus.count), 0);
    wait_done(lat);
    chk("re_lat", 32'(lat), 4);
    go(1, 0, 0);
    step();
    reset = 1;
    step();
    reset = 0;
    chk("rx_done", 32'(bus.done), 0);
    chk("rx_busy", 32'(bus.busy), 0);
    chk("rx_count", 32'(bus.count), 0);
    chk("rx_expired", 32'(bus.expired), 0);
    for (int i = 0; i < 1500; i++) begin
      bus.start = ($urandom_range(0, 14) == 0);
      bus.stop = ($urandom_range(0, 39) == 0);
      bus.en = ($urandom_range(0, 99) < 85);
      bus.clear = ($urandom_range(0, 9) == 0);
      bus.periodic = 1'($urandom_range(0, 1));
      bus.load_val = 16'($urandom_range(0, 4));
      bus.prescale = 8'($urandom_range(0, 2));
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
